// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, bus FSM states, interrupt cause codes and byte-strobe merge helper for the CLINT.
package clint_pkg;
  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;
  typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_e;
  localparam logic [3:0] IRQ_CAUSE_EXT   = 4'd11;
  localparam logic [3:0] IRQ_CAUSE_SW    = 4'd3;
  localparam logic [3:0] IRQ_CAUSE_TIMER = 4'd7;
  function automatic logic [63:0] apply_strobe(input logic [63:0] old, input logic [63:0] wdata, input logic [7:0] strb);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = strb[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: N-flop synchroniser for an asynchronous level input.
module irq_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else sync_q <= N'({sync_q, d_i});
  end
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/clint_irq_ctrl.sv
// clint_irq_ctrl: msip/mtimecmp/mtime bus registers, pending levels and prioritised interrupt request.
// Define CLINT_EXT_SYNC_EN to pass ext_irq through a 2-flop synchroniser before the pending register.
module clint_irq_ctrl
  import clint_pkg::*;
#(
  parameter int MTIME_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strobe,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  input  logic        ext_irq,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie_bits,
  output logic        swint,
  output logic        trint,
  output logic        exint,
  output logic        irq_valid,
  output logic [3:0]  irq_cause,
  input  logic        irq_ack
);
  localparam logic [7:0] DIV_LAST = 8'(MTIME_DIV - 1);
  bus_state_e  state_q, state_d;
  logic [63:0] rdata_q, rdata_d, mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [7:0]  presc_q, presc_d;
  logic        msip_q, msip_d, trint_q, swint_q, exint_q, ext_s;
  logic        irq_valid_q, irq_valid_d;
  logic [3:0]  irq_cause_q, irq_cause_d, top_cause;
  logic [2:0]  en;
  logic        accept, wr, sel_msip, sel_cmp, sel_mtime, tick, held_en;
`ifdef CLINT_EXT_SYNC_EN
  irq_sync #(.N(2)) u_sync (.clk(clk), .reset(reset), .d_i(ext_irq), .q_o(ext_s));
`else
  assign ext_s = ext_irq;
`endif
  assign accept    = req_valid & (state_q == BUS_IDLE);
  assign wr        = accept & req_write;
  assign sel_msip  = (req_addr & 16'hFFF8) == CLINT_MSIP;
  assign sel_cmp   = (req_addr & 16'hFFF8) == CLINT_MTIMECMP;
  assign sel_mtime = (req_addr & 16'hFFF8) == CLINT_MTIME;
  assign tick      = presc_q == DIV_LAST;
  // en bit order follows priority: {ext, sw, timer}
  assign en        = {exint_q & mie_bits[2], swint_q & mie_bits[0], trint_q & mie_bits[1]} & {3{mstatus_mie}};
  assign top_cause = en[2] ? IRQ_CAUSE_EXT : en[1] ? IRQ_CAUSE_SW : IRQ_CAUSE_TIMER;
  assign held_en   = (irq_cause_q == IRQ_CAUSE_EXT & en[2]) | (irq_cause_q == IRQ_CAUSE_SW & en[1]) |
                     (irq_cause_q == IRQ_CAUSE_TIMER & en[0]);
  always_comb begin
    state_d     = (state_q == BUS_IDLE) ? (req_valid ? BUS_RESP : BUS_IDLE) : (resp_ready ? BUS_IDLE : BUS_RESP);
    rdata_d     = !accept ? rdata_q : req_write ? '0 : sel_msip ? {63'd0, msip_q} :
                  sel_cmp ? mtimecmp_q : sel_mtime ? mtime_q : '0;
    msip_d      = (wr & sel_msip & req_strobe[0]) ? req_wdata[0] : msip_q;
    mtimecmp_d  = (wr & sel_cmp) ? apply_strobe(mtimecmp_q, req_wdata, req_strobe) : mtimecmp_q;
    // a bus write to mtime overrides the tick and restarts the prescaler
    mtime_d     = (wr & sel_mtime) ? apply_strobe(mtime_q, req_wdata, req_strobe) : tick ? mtime_q + 64'd1 : mtime_q;
    presc_d     = ((wr & sel_mtime) | tick) ? 8'd0 : presc_q + 8'd1;
    irq_valid_d = irq_valid_q ? (held_en & ~irq_ack) : |en;
    irq_cause_d = (irq_valid_q | ~|en) ? irq_cause_q : top_cause;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BUS_IDLE;
      rdata_q     <= '0;
      msip_q      <= 1'b0;
      mtimecmp_q  <= '1;
      mtime_q     <= '0;
      presc_q     <= '0;
      trint_q     <= 1'b0;
      swint_q     <= 1'b0;
      exint_q     <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_cause_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      presc_q     <= presc_d;
      trint_q     <= mtime_q >= mtimecmp_q;
      swint_q     <= msip_q;
      exint_q     <= ext_s;
      irq_valid_q <= irq_valid_d;
      irq_cause_q <= irq_cause_d;
    end
  end
  assign req_ready  = state_q == BUS_IDLE;
  assign resp_valid = state_q == BUS_RESP;
  assign resp_rdata = rdata_q;
  assign swint      = swint_q;
  assign trint      = trint_q;
  assign exint      = exint_q;
  assign irq_valid  = irq_valid_q;
  assign irq_cause  = irq_cause_q;
endmodule

// File: tb/tb_clint_irq_ctrl.sv
// tb_clint_irq_ctrl: directed bench; instance 0 runs MTIME_DIV=1, instance 1 runs MTIME_DIV=4.
module tb_clint_irq_ctrl;
`ifdef CLINT_EXT_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic        req_write = 1'b0, resp_ready = 1'b1, ext_irq = 1'b0, mstatus_mie = 1'b0, irq_ack = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_strobe = '0;
  logic [2:0]  mie_bits = '0;
  logic [1:0]  req_ready, resp_valid, swint, trint, exint, irq_valid;
  logic [63:0] resp_rdata [2];
  logic [3:0]  irq_cause [2];
  logic [63:0] rd, rd2;
  time         t0;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    clint_irq_ctrl #(.MTIME_DIV(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strobe(req_strobe), .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata[g]), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
      .mie_bits(mie_bits), .swint(swint[g]), .trint(trint[g]), .exint(exint[g]), .irq_valid(irq_valid[g]),
      .irq_cause(irq_cause[g]), .irq_ack(irq_ack)
    );
  end
  // starts on a negedge; returns on the negedge after the accept edge
  task automatic bus(input int d, input logic wr, input logic [15:0] a, input logic [63:0] wd,
                     input logic [7:0] st, output logic [63:0] rdo);
    int n = 0;
    req_write = wr; req_addr = a; req_wdata = wd; req_strobe = st;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    req_valid[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    tests++; if (resp_valid[d] !== 1'b1) begin fails++; $display("FAIL bus_resp_valid addr=%h: got %b want 1", a, resp_valid[d]); end
    rdo = resp_rdata[d];
  endtask
  task automatic test_reset;
    tests++; if (req_ready !== 2'b11) begin fails++; $display("FAIL reset_req_ready: got %b want 11", req_ready); end
    tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    tests++; if (resp_rdata[0] !== 64'd0) begin fails++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata[0]); end
    tests++; if ({swint[0], trint[0], exint[0]} !== 3'b000) begin fails++; $display("FAIL reset_pending: got %b want 000", {swint[0], trint[0], exint[0]}); end
    tests++; if (irq_valid[0] !== 1'b0) begin fails++; $display("FAIL reset_irq_valid: got %b want 0", irq_valid[0]); end
    tests++; if (irq_cause[0] !== 4'd0) begin fails++; $display("FAIL reset_irq_cause: got %0d want 0", irq_cause[0]); end
  endtask
  task automatic test_reads;
    repeat (10) @(negedge clk);
    bus(0, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'd10) begin fails++; $display("FAIL read_mtime: got %0d want 10", rd); end
    bus(0, 1'b0, 16'h4000, 64'd0, 8'h00, rd);
    tests++; if (rd !== '1) begin fails++; $display("FAIL read_mtimecmp: got %h want all ones", rd); end
    bus(0, 1'b0, 16'h4007, 64'd0, 8'h00, rd);
    tests++; if (rd !== '1) begin fails++; $display("FAIL read_mtimecmp_lowbits: got %h want all ones", rd); end
    bus(0, 1'b0, 16'h0100, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'd0) begin fails++; $display("FAIL read_unmapped: got %h want 0", rd); end
    bus(0, 1'b0, 16'h0000, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'd0) begin fails++; $display("FAIL read_msip: got %h want 0", rd); end
  endtask
  task automatic test_back_to_back;
    bus(0, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
    t0 = $time;
    bus(0, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd2);
    tests++; if ($time - t0 !== 20) begin fails++; $display("FAIL b2b_spacing: got %0t want 20", $time - t0); end
    tests++; if (rd2 - rd !== 64'd2) begin fails++; $display("FAIL b2b_mtime_delta: got %0d want 2", rd2 - rd); end
  endtask
  task automatic test_timer;
    mstatus_mie = 1'b1; mie_bits = 3'b010;
    bus(0, 1'b1, 16'hBFF8, 64'd0, 8'hFF, rd);
    tests++; if (rd !== 64'd0) begin fails++; $display("FAIL write_rdata: got %h want 0", rd); end
    bus(0, 1'b1, 16'h4000, 64'd20, 8'hFF, rd);
    repeat (18) @(negedge clk);
    tests++; if (trint[0] !== 1'b0) begin fails++; $display("FAIL timer_before: got %b want 0", trint[0]); end
    @(negedge clk);
    tests++; if (trint[0] !== 1'b1) begin fails++; $display("FAIL timer_trint: got %b want 1", trint[0]); end
    tests++; if (irq_valid[0] !== 1'b0) begin fails++; $display("FAIL timer_valid_early: got %b want 0", irq_valid[0]); end
    @(negedge clk);
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd7}) begin fails++; $display("FAIL timer_irq: got %b/%0d want 1/7", irq_valid[0], irq_cause[0]); end
    repeat (5) @(negedge clk);
    tests++; if (irq_valid[0] !== 1'b1) begin fails++; $display("FAIL timer_hold: got %b want 1", irq_valid[0]); end
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    tests++; if (irq_valid[0] !== 1'b0) begin fails++; $display("FAIL timer_ack_gap: got %b want 0", irq_valid[0]); end
    @(negedge clk);
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd7}) begin fails++; $display("FAIL timer_rearb: got %b/%0d want 1/7", irq_valid[0], irq_cause[0]); end
  endtask
  task automatic test_sw_frozen;
    mie_bits = 3'b011;
    bus(0, 1'b1, 16'h0000, 64'd1, 8'h01, rd);
    repeat (2) @(negedge clk);
    tests++; if (swint[0] !== 1'b1) begin fails++; $display("FAIL sw_swint: got %b want 1", swint[0]); end
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd7}) begin fails++; $display("FAIL sw_frozen: got %b/%0d want 1/7", irq_valid[0], irq_cause[0]); end
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    tests++; if (irq_valid[0] !== 1'b0) begin fails++; $display("FAIL sw_ack_gap: got %b want 0", irq_valid[0]); end
    @(negedge clk);
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd3}) begin fails++; $display("FAIL sw_cause: got %b/%0d want 1/3", irq_valid[0], irq_cause[0]); end
    bus(0, 1'b0, 16'h0000, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'd1) begin fails++; $display("FAIL sw_read_msip: got %h want 1", rd); end
  endtask
  task automatic test_ext;
    mie_bits = 3'b111; ext_irq = 1'b1;
    repeat (EXT_LAT - 1) @(negedge clk);
    tests++; if (exint[0] !== 1'b0) begin fails++; $display("FAIL ext_early: got %b want 0", exint[0]); end
    @(negedge clk);
    tests++; if (exint[0] !== 1'b1) begin fails++; $display("FAIL ext_exint: got %b want 1", exint[0]); end
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd3}) begin fails++; $display("FAIL ext_frozen: got %b/%0d want 1/3", irq_valid[0], irq_cause[0]); end
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    @(negedge clk);
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd11}) begin fails++; $display("FAIL ext_cause: got %b/%0d want 1/11", irq_valid[0], irq_cause[0]); end
    mie_bits = 3'b010; ext_irq = 1'b0;
    @(negedge clk);
    tests++; if (irq_valid[0] !== 1'b0) begin fails++; $display("FAIL ext_withdraw: got %b want 0", irq_valid[0]); end
    @(negedge clk);
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd7}) begin fails++; $display("FAIL ext_to_timer: got %b/%0d want 1/7", irq_valid[0], irq_cause[0]); end
  endtask
  task automatic test_withdraw;
    mie_bits = 3'b000;
    @(negedge clk);
    tests++; if (irq_valid[0] !== 1'b0) begin fails++; $display("FAIL withdraw_mtie: got %b want 0", irq_valid[0]); end
    irq_ack = 1'b1; mie_bits = 3'b010;
    @(negedge clk); irq_ack = 1'b0;
    tests++; if ({irq_valid[0], irq_cause[0]} !== {1'b1, 4'd7}) begin fails++; $display("FAIL withdraw_ack_ignored: got %b/%0d want 1/7", irq_valid[0], irq_cause[0]); end
  endtask
  task automatic test_stall;
    resp_ready = 1'b0;
    bus(0, 1'b0, 16'h4000, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'd20) begin fails++; $display("FAIL stall_rdata: got %h want 20", rd); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if ({resp_valid[0], req_ready[0], resp_rdata[0]} !== {2'b10, 64'd20}) begin
        fails++; $display("FAIL stall_hold[%0d]: got v=%b r=%b d=%h want v=1 r=0 d=14", i, resp_valid[0], req_ready[0], resp_rdata[0]);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    tests++; if ({resp_valid[0], req_ready[0]} !== 2'b01) begin fails++; $display("FAIL stall_release: got v=%b r=%b want v=0 r=1", resp_valid[0], req_ready[0]); end
  endtask
  task automatic test_strobe_tick;
    bus(1, 1'b1, 16'hBFF8, 64'hAAAA_BBBB_0000_0000, 8'hFF, rd);
    repeat (3) @(negedge clk);
    bus(1, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_0000_1234, 8'h0F, rd);
    bus(1, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'hAAAA_BBBB_0000_1234) begin fails++; $display("FAIL strobe_mtime: got %h want aaaabbbb00001234", rd); end
    bus(1, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
    bus(1, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
    tests++; if (rd !== 64'hAAAA_BBBB_0000_1235) begin fails++; $display("FAIL strobe_next_tick: got %h want aaaabbbb00001235", rd); end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    test_reset;
    test_reads;
    test_back_to_back;
    test_timer;
    test_sw_frozen;
    test_ext;
    test_withdraw;
    test_stall;
    test_strobe_tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
